// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Fetch control states: issuing a request, waiting for its response,
  // holding a returned word while decode stalls, and draining the
  // response of a request that a redirect has killed.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  // addi x0,x0,0 -- the canonical RISC-V NOP placed in decode on a bubble.
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

  // Default program counter after reset.
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register that parks a returned instruction word while
// decode is stalled. 'clear' takes priority over 'load'.
module fetch_hold_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Occupancy flag: set on load, dropped on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload register, written only on load.
  // NOTE: the payload has no reset; 'valid' qualifies it, so resetting the
  // data bits would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= data_in;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns PCF, drives a valid/ready request to
// instruction memory with at most one request outstanding, accepts a
// variable-latency response, applies EX redirects and hazard stall/flush,
// and drives the F/D pipeline registers.
// Optional build macro FETCH_PERF_CNT_EN enables the fetch/discard
// performance counters; without it both counter ports read 0.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(FETCH_RESET_PC),
  parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = WORD_WIDTH'(FETCH_NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  flushD,
  input  logic                  PCSrcE,
  input  logic [WORD_WIDTH-1:0] PCTargetE,
  output logic                  imem_req_valid,
  output logic [WORD_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] imem_rsp_data,
  output logic [WORD_WIDTH-1:0] instrD,
  output logic [WORD_WIDTH-1:0] PCD,
  output logic [WORD_WIDTH-1:0] PCPlus4D,
  output logic                  validD,
  output logic [31:0]           fetch_count,
  output logic [31:0]           discard_count
);

  fetch_state_t          state_q, state_d;
  logic [WORD_WIDTH-1:0] pcf_q, pcf_d;
  logic                  req_en_q;      // low until the first clock after reset
  logic [WORD_WIDTH-1:0] target_aligned;
  logic [WORD_WIDTH-1:0] pcf_plus4;
  logic [WORD_WIDTH-1:0] word;
  logic                  accept;
  logic                  deliver;       // a word leaves fetch for decode
  logic                  load_fd;       // that word actually lands in F/D
  logic                  discard;       // a response is thrown away
  logic                  hold_load;
  logic                  hold_clear;
  logic [WORD_WIDTH-1:0] hold_data;
  logic                  hold_valid;

  assign target_aligned = PCTargetE & ~WORD_WIDTH'(3);
  assign pcf_plus4      = pcf_q + WORD_WIDTH'(4);
  assign imem_req_valid = req_en_q && (state_q == S_REQ);
  assign imem_req_addr  = pcf_q;
  assign accept         = imem_req_valid & imem_req_ready;
  // A flush squashes the delivered word even though fetch moves past it.
  assign load_fd        = deliver & ~flushD;

  fetch_hold_buf #(
    .WIDTH (WORD_WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .data_in (imem_rsp_data),
    .data    (hold_data),
    .valid   (hold_valid)
  );

  // Next-state, next-PC and event decode for the fetch FSM.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    word       = hold_data;
    deliver    = 1'b0;
    discard    = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state_q)
      S_REQ: begin
        if (accept) state_d = PCSrcE ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (PCSrcE) begin
            discard = 1'b1;
            state_d = S_REQ;
          end else if (stallF) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            deliver = 1'b1;
            word    = imem_rsp_data;
            state_d = S_REQ;
          end
        end else if (PCSrcE) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          discard    = hold_valid;
          hold_clear = 1'b1;
          state_d    = S_REQ;
        end else if (!stallF) begin
          deliver    = 1'b1;
          hold_clear = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        // The killed response retires the only outstanding request, so a
        // redirect landing in the same cycle can be requested right away.
        if (imem_rsp_valid) begin
          discard = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (PCSrcE)       pcf_d = target_aligned;
    else if (deliver) pcf_d = pcf_plus4;
  end

  // Fetch state, program counter and request enable.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pcf_q    <= RESET_PC;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      req_en_q <= 1'b1;
    end
  end

  // F/D pipeline registers: flush > stall > load > bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD   <= NOP_INSTR;
      validD   <= 1'b0;
    end else if (stallF) begin
      // hold everything
    end else if (load_fd) begin
      instrD   <= word;
      PCD      <= pcf_q;
      PCPlus4D <= pcf_plus4;
      validD   <= 1'b1;
    end else begin
      instrD   <= NOP_INSTR;
      validD   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] discard_cnt_q;

  // Performance counters for loaded and discarded words; wrap modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (load_fd) fetch_cnt_q   <= fetch_cnt_q + 32'd1;
      if (discard) discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign fetch_count   = fetch_cnt_q;
  assign discard_count = discard_cnt_q;
`else
  // The discard strobe only feeds the counters, which are absent here.
  logic perf_unused;
  assign perf_unused   = discard;
  assign fetch_count   = '0;
  assign discard_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: one vector per clock
// with hand-computed expectations, plus hand-written reset sequences.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 29;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, flushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;
  logic [31:0] fetch_count, discard_count;

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .flushD         (flushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instrD         (instrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .validD         (validD),
    .fetch_count    (fetch_count),
    .discard_count  (discard_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, src;
    logic [31:0] tgt;
    logic        ready, rv;
    logic [31:0] rdata;
    logic        ev;      // expected imem_req_valid before the edge
    logic [31:0] ea;      // expected imem_req_addr (checked when ev)
    logic [31:0] ei;      // expected instrD after the edge
    logic        evd;     // expected validD after the edge
    logic        chk_pd;  // also check PCD/PCPlus4D
    logic [31:0] epd;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic stall, input logic flush, input logic src,
                              input logic [31:0] tgt, input logic ready, input logic rv,
                              input logic [31:0] rdata, input logic ev, input logic [31:0] ea,
                              input logic [31:0] ei, input logic evd, input logic chk_pd,
                              input logic [31:0] epd);
    vec_t v;
    v.stall = stall; v.flush = flush; v.src = src; v.tgt = tgt;
    v.ready = ready; v.rv = rv; v.rdata = rdata;
    v.ev = ev; v.ea = ea; v.ei = ei; v.evd = evd; v.chk_pd = chk_pd; v.epd = epd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic idle_inputs();
    stallF = 1'b0; flushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
  endtask

  logic [31:0] exp_fetch, exp_disc;

  initial begin
    //                stl fl src tgt           rdy rv data          ev ea            instrD        vD chk PCD
    // zero-wait stream of 0xA, 0xB, 0xC with a bubble between each word
    vecs[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        1, 1, 32'hA,        0, 32'h0,        32'hA,        1, 1, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        NOP,          0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        1, 1, 32'hB,        0, 32'h0,        32'hB,        1, 1, 32'h4);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        NOP,          0, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,        1, 1, 32'hC,        0, 32'h0,        32'hC,        1, 1, 32'h8);
    // response arrives under a 3-cycle stall, held, then released
    vecs[6]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hC,        NOP,          0, 0, 32'h0);
    vecs[7]  = mk(1, 0, 0, 32'h0,        0, 1, 32'h00500093, 0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[8]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[9]  = mk(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h00500093, 1, 1, 32'hC);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       NOP,          0, 0, 32'h0);
    // redirect while waiting: drain the killed response, then fetch 0x40
    vecs[12] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h10,       NOP,          0, 0, 32'h0);
    vecs[13] = mk(0, 0, 1, 32'h40,       0, 0, 32'h0,        0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,        0, 1, 32'hDEAD,     0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h40,       NOP,          0, 0, 32'h0);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 1, 32'h11,       0, 32'h0,        32'h11,       1, 1, 32'h40);
    // redirect coincident with the response (target low bits ignored)
    vecs[18] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h44,       NOP,          0, 0, 32'h0);
    vecs[19] = mk(0, 0, 1, 32'h43,       0, 1, 32'h22,       0, 32'h0,        NOP,          0, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       NOP,          0, 0, 32'h0);
    // redirect in S_REQ before acceptance retargets the request
    vecs[21] = mk(0, 0, 1, 32'h80,       0, 0, 32'h0,        1, 32'h40,       NOP,          0, 0, 32'h0);
    vecs[22] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80,       NOP,          0, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 32'h0,        0, 1, 32'h33,       0, 32'h0,        32'h33,       1, 1, 32'h80);
    // flush and stall together: validD drops, NOP inserted, PCD unchanged
    vecs[24] = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h84,       NOP,          0, 1, 32'h80);
    // PC+4 wraps from 0xFFFF_FFFC to 0
    vecs[25] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'h84,       NOP,          0, 0, 32'h0);
    vecs[26] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, NOP,          0, 0, 32'h0);
    vecs[27] = mk(0, 0, 0, 32'h0,        0, 1, 32'h44,       0, 32'h0,        32'h44,       1, 1, 32'hFFFFFFFC);
    vecs[28] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        NOP,          0, 0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd7;
    exp_disc  = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_disc  = 32'd0;
`endif

    // ---- reset state ----
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("reset req_addr", imem_req_addr, 32'h0);
    check("reset instrD", instrD, 32'h0);
    check("reset PCD", PCD, 32'h0);
    check("reset validD", {31'd0, validD}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stallF = vecs[i].stall; flushD = vecs[i].flush; PCSrcE = vecs[i].src;
      PCTargetE = vecs[i].tgt; imem_req_ready = vecs[i].ready;
      imem_rsp_valid = vecs[i].rv; imem_rsp_data = vecs[i].rdata;
      #1;
      check($sformatf("v%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) check($sformatf("v%0d req_addr", i), imem_req_addr, vecs[i].ea);
      @(posedge clk);
      #1;
      check($sformatf("v%0d instrD", i), instrD, vecs[i].ei);
      check($sformatf("v%0d validD", i), {31'd0, validD}, {31'd0, vecs[i].evd});
      if (vecs[i].chk_pd) begin
        check($sformatf("v%0d PCD", i), PCD, vecs[i].epd);
        check($sformatf("v%0d PCPlus4D", i), PCPlus4D, vecs[i].epd + 32'd4);
      end
    end
    check("fetch_count", fetch_count, exp_fetch);
    check("discard_count", discard_count, exp_disc);

    // ---- async reset in the middle of S_WAIT ----
    @(negedge clk);
    idle_inputs();
    imem_req_ready = 1'b1;                 // request at PC 0 accepted
    @(negedge clk);
    idle_inputs();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55;
    @(posedge clk);
    #1;
    check("pre-reset validD", {31'd0, validD}, 32'd1);
    @(negedge clk);
    idle_inputs();
    imem_req_ready = 1'b1;                 // request at PC 4 accepted -> S_WAIT
    @(posedge clk);
    #2;
    imem_req_ready = 1'b0;
    reset = 1'b0;                          // asserted between clock edges
    #1;
    check("async req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("async instrD", instrD, 32'h0);
    check("async PCD", PCD, 32'h0);
    check("async PCPlus4D", PCPlus4D, 32'h0);
    check("async validD", {31'd0, validD}, 32'd0);
    check("async fetch_count", fetch_count, 32'd0);
    check("async discard_count", discard_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release req_valid early", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("release req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("release req_addr", imem_req_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch against an instruction memory with a valid/ready request and variable-latency response, in place of the zero-latency combinational imem path.
- Owns PCF, issues at most one outstanding request, and buffers a returned word while decode is stalled.
- Applies EX-stage redirects (PCSrcE/PCTargetE) and hazard-unit stall/flush, then drives the F/D pipeline registers (instrD, PCD, PCPlus4D, validD).

Parameters:
- WORD_WIDTH, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, instrD value on flush or bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- stallF  input  1  hazard unit: hold fetch and F/D registers.
- flushD  input  1  hazard unit: squash the F/D register.
- PCSrcE  input  1  redirect request from EX.
- PCTargetE  input  WORD_WIDTH  redirect target.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  WORD_WIDTH  byte address (= PCF).
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response word valid; exactly one per accepted request, never in the same cycle as acceptance.
- imem_rsp_data  input  WORD_WIDTH  instruction word.
- instrD  output  WORD_WIDTH  decode-stage instruction.
- PCD  output  WORD_WIDTH  decode-stage PC.
- PCPlus4D  output  WORD_WIDTH  PCD+4.
- validD  output  1  decode slot holds a real instruction.
- fetch_count  output  32  performance counter; see Optional Feature.
- discard_count  output  32  performance counter; see Optional Feature.

Behaviour:
- Reset (async, asserts immediately):
  - PCF=RESET_PC, state=S_REQ, hold buffer empty.
  - instrD=0, PCD=0, PCPlus4D=0, validD=0, counters=0.
  - imem_req_valid=0 while reset is low; it asserts from the first clock after release.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=PCF.
  - Handshake when valid&ready: go to S_WAIT.
  - The address may change before acceptance (redirect only).
- S_WAIT:
  - On rsp_valid with stallF=0: load instrD=rsp_data, PCD=PCF, PCPlus4D=PCF+4, validD=1; PCF<=PCF+4; go to S_REQ.
  - On rsp_valid with stallF=1: capture the word into the hold buffer; go to S_HOLD.
- S_HOLD:
  - No request is issued.
  - When stallF falls to 0: load F/D from the hold buffer (same rule as S_WAIT), advance PCF, go to S_REQ.
- S_DRAIN:
  - Waits for the response of a killed request.
  - On rsp_valid: discard the word, go to S_REQ.
- Redirect (PCSrcE=1) has highest priority; PCF<=PCTargetE in every state:
  - S_REQ, not accepted this cycle: stay in S_REQ; the next cycle requests PCTargetE.
  - S_REQ, accepted this cycle: go to S_DRAIN.
  - S_WAIT, rsp_valid this cycle: discard the word, go to S_REQ.
  - S_WAIT, no rsp_valid this cycle: go to S_DRAIN.
  - S_HOLD: drop the buffer, go to S_REQ.
  - S_DRAIN: stay in S_DRAIN with the new PCF.
- F/D register update rules:
  - Priority is flushD > stallF > load > bubble.
  - flushD=1: validD<=0, instrD<=NOP_INSTR; PCD and PCPlus4D hold.
  - stallF=1 (no flush): all F/D outputs hold.
  - stallF=0, no word delivered this cycle: bubble, validD<=0, instrD<=NOP_INSTR.
  - A redirect in the same cycle as a deliverable response discards that response; it never reaches decode.
- Arithmetic: PC+4 is modulo 2^WORD_WIDTH, so 32'hFFFF_FFFC wraps to 0. PCTargetE[1:0] is ignored and forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments on each word loaded into F/D.
  - discard_count increments on each response discarded (redirect or S_DRAIN).
  - Both counters wrap modulo 2^32.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {S_REQ, S_WAIT, S_HOLD, S_DRAIN}, NOP_INSTR constant, RESET_PC default.
- Sub-module fetch_hold_buf: a one-entry holding register with load/clear/valid, async active-low reset.
- Control FSM and F/D registers stay in fetch_sequencer.

Test Plan:
- Zero-wait stream: ready=1, responses 1 cycle after accept, words 0xA,0xB,0xC. Result: instrD/PCD = (0xA,0x0),(0xB,0x4),(0xC,0x8) with validD=1; a bubble appears between them since there is one outstanding request.
- Stall during wait: rsp 0x00500093 arrives with stallF=1 for 3 cycles. Result: S_HOLD, no imem_req_valid, F/D held; on release instrD=0x00500093 and the next request goes to PC+4.
- Redirect while waiting: accept at PC 0x10, PCSrcE=1 with PCTargetE=0x40 before rsp. Result: the response is discarded (discard_count=1), the next request address is 0x40, and validD stays 0 until 0x40's word arrives.
- Redirect coincident with rsp_valid: the word is dropped, the next request is 0x40, and no S_DRAIN is entered.
- Flush+stall same cycle: validD=1 initially. Result: next cycle validD=0, instrD=0x00000013, PCD unchanged.
- Async reset mid-S_WAIT: reset=0 between clocks. Result: outputs clear immediately, imem_req_valid=0; after release the first request is at RESET_PC.
